sram_serial_loader: RTL and testbench

SRAM_SERIAL_LOADER -- requirements
Module: sram_serial_loader

---
 rtl/sram_serial_loader_pkg.sv | 15 +
 rtl/sram_loader_fifo.sv | 46 ++++
 rtl/sram_serial_loader.sv | 166 ++++++++++++++++
 tb/tb_sram_serial_loader.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_serial_loader_pkg.sv
// Shared FSM encoding, controller command and default widths for the SRAM serial loader.
package sram_serial_loader_pkg;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_ADDR_WIDTH  = 9;
  localparam int DEF_RDY_TIMEOUT = 32;

  localparam logic [1:0] CTRL_WRITE = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT    = 2'd1,
    ST_WAIT_RDY = 2'd2,
    ST_GAP      = 2'd3
  } state_t;
endpackage

// File: rtl/sram_loader_fifo.sv
// Two-entry request buffer; head visible combinationally, a write is stored in one cycle.
// in_rdy is low only when both entries are occupied; a pop and a push may share a cycle.
module sram_loader_fifo #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             push;
  logic             pop;

  assign in_rdy  = (count != 2'd2);
  assign out_vld = (count != 2'd0);
  assign push    = in_vld && in_rdy;
  assign pop     = out_rdy && out_vld;
  assign out_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/sram_serial_loader.sv
// Serialises buffered {addr,data} writes LSB-first to an SRAM IO controller; BGN rises the cycle after a frame is popped.
// WR_READY drops while the 2-entry buffer is full; a frame waits for RDY or a timeout, then one BGN-low gap.
module sram_serial_loader #(
  parameter int DATA_WIDTH  = sram_serial_loader_pkg::DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = sram_serial_loader_pkg::DEF_ADDR_WIDTH,
  parameter int FRAME_WIDTH = ADDR_WIDTH + DATA_WIDTH,
  parameter int RDY_TIMEOUT = sram_serial_loader_pkg::DEF_RDY_TIMEOUT
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  WR_VALID,
  input  logic [ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  WR_READY,
  input  logic                  RDY,
  output logic                  BGN,
  output logic                  SI,
  output logic                  LOAD_N,
  output logic [1:0]            CTRL,
  output logic                  BUSY,
  output logic                  ERR,
  output logic [7:0]            FRAME_CNT
);
  import sram_serial_loader_pkg::*;

  localparam int BW = $clog2(FRAME_WIDTH + 1);
  localparam int TW = $clog2(RDY_TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_WIDTH - 1);
  localparam logic [TW-1:0] LAST_WAIT = TW'(RDY_TIMEOUT - 1);

  state_t                 st;
  state_t                 st_nxt;
  logic                   fifo_vld;
  logic                   pop;
  logic                   push;
  logic                   frame_done;
  logic                   timeout;
  logic                   busy_nxt;
  logic [1:0]             fifo_cnt;
  logic [1:0]             fifo_cnt_nxt;
  logic [FRAME_WIDTH-1:0] fifo_dat;
  logic [FRAME_WIDTH-1:0] sreg;
  logic [BW-1:0]          bit_cnt;
  logic [TW-1:0]          wait_cnt;
  logic                   bgn_q;
  logic                   si_q;
  logic                   busy_q;
  logic                   load_n_q;
  logic                   err_q;
  logic [7:0]             frame_cnt_q;

  sram_loader_fifo #(
    .WIDTH (FRAME_WIDTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .in_vld  (WR_VALID),
    .in_rdy  (WR_READY),
    .in_dat  (FRAME_WIDTH'({WR_ADDR, WR_DATA})),
    .out_vld (fifo_vld),
    .out_rdy (pop),
    .out_dat (fifo_dat),
    .count   (fifo_cnt)
  );

  assign push         = WR_VALID && WR_READY;
  assign fifo_cnt_nxt = fifo_cnt + {1'b0, push} - {1'b0, pop};
  assign busy_nxt     = (st_nxt != ST_IDLE) || (fifo_cnt_nxt != 2'd0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st <= ST_IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  always_comb begin
    st_nxt     = st;
    pop        = 1'b0;
    frame_done = 1'b0;
    timeout    = 1'b0;
    case (st)
      ST_IDLE: begin
        if (fifo_vld) begin
          st_nxt = ST_SHIFT;
          pop    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt == LAST_BIT) begin
          st_nxt = ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        if (RDY) begin
          st_nxt     = ST_GAP;
          frame_done = 1'b1;
        end else if (wait_cnt == LAST_WAIT) begin
          st_nxt  = ST_GAP;
          timeout = 1'b1;
        end
      end
      ST_GAP: begin
        // A queued frame launches straight from the gap so frames are spaced by one BGN-low cycle.
        if (fifo_vld) begin
          st_nxt = ST_SHIFT;
          pop    = 1'b1;
        end else begin
          st_nxt = ST_IDLE;
        end
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sreg        <= '0;
      bit_cnt     <= '0;
      wait_cnt    <= '0;
      bgn_q       <= 1'b0;
      si_q        <= 1'b0;
      busy_q      <= 1'b0;
      load_n_q    <= 1'b1;
      err_q       <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      if (pop) begin
        si_q    <= fifo_dat[0];
        sreg    <= fifo_dat >> 1;
        bit_cnt <= '0;
      end else if (st == ST_SHIFT) begin
        if (st_nxt == ST_SHIFT) begin
          si_q    <= sreg[0];
          sreg    <= sreg >> 1;
          bit_cnt <= bit_cnt + 1'b1;
        end else begin
          si_q <= 1'b0;
        end
      end
      if ((st == ST_WAIT_RDY) && (st_nxt == ST_WAIT_RDY)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      bgn_q    <= (st_nxt == ST_SHIFT) || (st_nxt == ST_WAIT_RDY);
      busy_q   <= busy_nxt;
      load_n_q <= !busy_nxt;
      if (timeout) begin
        err_q <= 1'b1;
      end
      if (frame_done) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign BGN       = bgn_q;
  assign SI        = si_q;
  assign LOAD_N    = load_n_q;
  assign CTRL      = CTRL_WRITE;
  assign BUSY      = busy_q;
  assign ERR       = err_q;
  assign FRAME_CNT = frame_cnt_q;
endmodule

// File: tb/tb_sram_serial_loader.sv
// Bench: model SRAM IO controller + SRAM capture frames; per-scenario tasks compare against bench-side expectations.
module tb_sram_serial_loader;
  localparam int DW = 8;
  localparam int AW = 9;
  localparam int FW = AW + DW;
  localparam int TO = 32;

  logic          CLK;
  logic          RST_N;
  logic          WR_VALID;
  logic [AW-1:0] WR_ADDR;
  logic [DW-1:0] WR_DATA;
  logic          WR_READY;
  logic          RDY;
  logic          BGN;
  logic          SI;
  logic          LOAD_N;
  logic [1:0]    CTRL;
  logic          BUSY;
  logic          ERR;
  logic [7:0]    FRAME_CNT;

  int n_checks;
  int n_fails;

  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] cap_q[$];
  int            gap_q[$];
  int            hi_q[$];
  int            exp_hi_q[$];
  logic [DW-1:0] sram_mem [512];
  logic [DW-1:0] ref_mem [512];
  bit            ref_vld [512];

  int            drop_req;
  bit            noise_en;
  int            nbits;
  int            low_run;
  int            hi_run;
  int            wait_left;
  int            dropped;
  bit            in_wait;
  bit            respond;
  bit            prev_bgn;
  logic [FW-1:0] fr;
  logic [7:0]    exp_cnt;

  sram_serial_loader #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .FRAME_WIDTH (FW),
    .RDY_TIMEOUT (TO)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .WR_VALID  (WR_VALID),
    .WR_ADDR   (WR_ADDR),
    .WR_DATA   (WR_DATA),
    .WR_READY  (WR_READY),
    .RDY       (RDY),
    .BGN       (BGN),
    .SI        (SI),
    .LOAD_N    (LOAD_N),
    .CTRL      (CTRL),
    .BUSY      (BUSY),
    .ERR       (ERR),
    .FRAME_CNT (FRAME_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model controller: first FW cycles of BGN are frame bits, then RDY after a random delay (or never).
  initial begin
    RDY = 1'b0; nbits = 0; low_run = 0; hi_run = 0; wait_left = 0; dropped = 0;
    in_wait = 1'b0; respond = 1'b0; prev_bgn = 1'b0; fr = '0; exp_cnt = 8'd0;
    forever begin
      @(negedge CLK);
      RDY = 1'b0;
      if (!RST_N) begin
        nbits = 0; in_wait = 1'b0; respond = 1'b0; low_run = 0; hi_run = 0; exp_cnt = 8'd0;
      end else if (BGN) begin
        if (!prev_bgn) begin
          gap_q.push_back(low_run);
          low_run = 0; hi_run = 0; nbits = 0; in_wait = 1'b0;
        end
        hi_run++;
        if (!in_wait) begin
          fr[nbits] = SI;
          nbits++;
          if (noise_en) RDY = ($urandom_range(0, 2) == 0);
          if (nbits == FW) begin
            in_wait = 1'b1;
            cap_q.push_back(fr);
            if (dropped < drop_req) begin
              dropped++;
              respond = 1'b0;
              exp_hi_q.push_back(FW + TO);
            end else begin
              respond = 1'b1;
              wait_left = $urandom_range(0, 4);
              exp_hi_q.push_back(FW + wait_left + 1);
            end
          end
        end else if (respond) begin
          if (wait_left == 0) begin
            RDY = 1'b1;
            sram_mem[fr[FW-1 -: AW]] = fr[DW-1:0];
            respond = 1'b0;
            exp_cnt = exp_cnt + 8'd1;
          end else begin
            wait_left--;
          end
        end
      end else begin
        if (prev_bgn) hi_q.push_back(hi_run);
        low_run++;
        if (noise_en) RDY = ($urandom_range(0, 2) == 0);
      end
      prev_bgn = RST_N && BGN;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d fails=%0d", n_checks, n_fails);
    $fatal(1, "watchdog");
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    @(negedge CLK);
    while (WR_READY !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    n_checks++;
    if (WR_READY !== 1'b1) begin
      n_fails++;
      $display("FAIL write_ready_wait: WR_READY=%b after %0d cycles, want 1", WR_READY, n);
    end
    WR_VALID = 1'b1; WR_ADDR = a; WR_DATA = d;
    @(negedge CLK);
    WR_VALID = 1'b0;
    exp_q.push_back({a, d});
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int quiet;
    int n;
    quiet = 0; n = 0;
    while (quiet < 4 && n < budget) begin
      @(negedge CLK);
      n++;
      if (BUSY === 1'b0 && BGN === 1'b0) quiet++;
      else quiet = 0;
    end
    n_checks++;
    if (quiet < 4) begin
      n_fails++;
      $display("FAIL %s_idle: BUSY=%b BGN=%b after %0d cycles, want idle", nm, BUSY, BGN, n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    n_checks++; if (BGN !== 1'b0)     begin n_fails++; $display("FAIL reset_bgn: got %b want 0", BGN); end
    n_checks++; if (SI !== 1'b0)      begin n_fails++; $display("FAIL reset_si: got %b want 0", SI); end
    n_checks++; if (LOAD_N !== 1'b1)  begin n_fails++; $display("FAIL reset_load_n: got %b want 1", LOAD_N); end
    n_checks++; if (CTRL !== 2'b00)   begin n_fails++; $display("FAIL reset_ctrl: got %b want 00", CTRL); end
    n_checks++; if (BUSY !== 1'b0)    begin n_fails++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    n_checks++; if (ERR !== 1'b0)     begin n_fails++; $display("FAIL reset_err: got %b want 0", ERR); end
    n_checks++; if (FRAME_CNT !== 8'd0) begin n_fails++; $display("FAIL reset_frame_cnt: got %0d want 0", FRAME_CNT); end
    n_checks++; if (WR_READY !== 1'b1) begin n_fails++; $display("FAIL reset_wr_ready: got %b want 1", WR_READY); end
    #2 RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({BUSY, BGN, LOAD_N} !== 3'b001) begin
      n_fails++;
      $display("FAIL reset_release_idle: BUSY,BGN,LOAD_N=%b want 001", {BUSY, BGN, LOAD_N});
    end
  endtask

  task automatic test_single();
    int c0;
    int h0;
    logic [FW-1:0] want_seq;
    bit seq_bits [FW] = '{0,1,0,0,0,0,1,0, 0,0,0,0,0,1,0,0,0};
    c0 = cap_q.size(); h0 = hi_q.size();
    for (int k = 0; k < FW; k++) want_seq[k] = seq_bits[k];
    do_write(9'h020, 8'h42);
    n_checks++;
    if ({BUSY, LOAD_N} !== 2'b10) begin
      n_fails++;
      $display("FAIL single_busy_load_n: BUSY,LOAD_N=%b want 10", {BUSY, LOAD_N});
    end
    wait_idle(300, "single");
    n_checks++;
    if (cap_q.size() != c0 + 1) begin
      n_fails++;
      $display("FAIL single_frame_count: captured %0d frames want 1", cap_q.size() - c0);
    end else begin
      n_checks++;
      if (cap_q[c0] !== want_seq) begin
        n_fails++;
        $display("FAIL single_si_sequence: got %b want %b (bit0 rightmost)", cap_q[c0], want_seq);
      end
      n_checks++;
      if (hi_q.size() <= h0 || hi_q[h0] !== exp_hi_q[h0]) begin
        n_fails++;
        $display("FAIL single_bgn_len: got %0d want %0d", (hi_q.size() > h0) ? hi_q[h0] : -1, exp_hi_q[h0]);
      end
    end
    n_checks++;
    if (FRAME_CNT !== 8'd1) begin n_fails++; $display("FAIL single_frame_cnt: got %0d want 1", FRAME_CNT); end
    n_checks++;
    if (sram_mem[9'h020] !== 8'h42) begin
      n_fails++;
      $display("FAIL single_sram: got %h want 42", sram_mem[9'h020]);
    end
  endtask

  task automatic test_back_to_back();
    int c0, g0, h0, e0, idx, cyc, n;
    logic r;
    logic [AW-1:0] a [3];
    logic [DW-1:0] d [3];
    logic [2:0] rdy_log;
    noise_en = 1'b1;
    c0 = cap_q.size(); g0 = gap_q.size(); h0 = hi_q.size(); e0 = exp_q.size();
    rdy_log = 3'b000;
    do_write(AW'($urandom), DW'($urandom));
    n = 0;
    while (BGN !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
    n_checks++;
    if (BGN !== 1'b1) begin n_fails++; $display("FAIL b2b_lead_start: BGN=%b want 1", BGN); end
    for (int k = 0; k < 3; k++) begin a[k] = AW'($urandom); d[k] = DW'($urandom); end
    idx = 0; cyc = 0;
    while (idx < 3 && cyc < 200) begin
      WR_VALID = 1'b1; WR_ADDR = a[idx]; WR_DATA = d[idx];
      r = WR_READY;
      if (cyc < 3) rdy_log[2-cyc] = r;
      @(negedge CLK);
      if (r) begin exp_q.push_back({a[idx], d[idx]}); idx++; end
      cyc++;
    end
    WR_VALID = 1'b0;
    n_checks++;
    if (rdy_log !== 3'b110 || idx != 3) begin
      n_fails++;
      $display("FAIL b2b_wr_ready: first three WR_READY=%b accepted=%0d want 110 and 3", rdy_log, idx);
    end
    wait_idle(600, "b2b");
    n_checks++;
    if (cap_q.size() - c0 != 4 || gap_q.size() - g0 != 4 || hi_q.size() - h0 != 4) begin
      n_fails++;
      $display("FAIL b2b_frames: frames=%0d gaps=%0d want 4", cap_q.size() - c0, gap_q.size() - g0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (cap_q[c0+i] !== exp_q[e0+i]) begin
          n_fails++;
          $display("FAIL b2b_order[%0d]: got %h want %h", i, cap_q[c0+i], exp_q[e0+i]);
        end
        n_checks++;
        if (hi_q[h0+i] !== exp_hi_q[h0+i]) begin
          n_fails++;
          $display("FAIL b2b_bgn_len[%0d]: got %0d want %0d", i, hi_q[h0+i], exp_hi_q[h0+i]);
        end
      end
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (gap_q[g0+i] !== 1) begin
          n_fails++;
          $display("FAIL b2b_gap[%0d]: BGN low for %0d cycles want 1", i, gap_q[g0+i]);
        end
      end
    end
    n_checks++;
    if (FRAME_CNT !== exp_cnt) begin n_fails++; $display("FAIL b2b_frame_cnt: got %0d want %0d", FRAME_CNT, exp_cnt); end
    noise_en = 1'b0;
  endtask

  task automatic test_timeout();
    int c0, g0, h0, e0;
    logic [7:0] cnt_before;
    c0 = cap_q.size(); g0 = gap_q.size(); h0 = hi_q.size(); e0 = exp_q.size();
    cnt_before = exp_cnt;
    n_checks++;
    if (ERR !== 1'b0) begin n_fails++; $display("FAIL timeout_err_before: got %b want 0", ERR); end
    drop_req = drop_req + 1;
    do_write(AW'($urandom), DW'($urandom));
    do_write(AW'($urandom), DW'($urandom));
    wait_idle(400, "timeout");
    n_checks++;
    if (ERR !== 1'b1) begin n_fails++; $display("FAIL timeout_err: got %b want 1", ERR); end
    n_checks++;
    if (FRAME_CNT !== cnt_before + 8'd1) begin
      n_fails++;
      $display("FAIL timeout_frame_cnt: got %0d want %0d", FRAME_CNT, cnt_before + 8'd1);
    end
    n_checks++;
    if (cap_q.size() - c0 != 2 || hi_q.size() - h0 != 2 || gap_q.size() - g0 != 2) begin
      n_fails++;
      $display("FAIL timeout_frames: frames=%0d want 2", cap_q.size() - c0);
    end else begin
      n_checks++;
      if (hi_q[h0] !== FW + TO) begin
        n_fails++;
        $display("FAIL timeout_bgn_len: got %0d want %0d", hi_q[h0], FW + TO);
      end
      n_checks++;
      if (cap_q[c0+1] !== exp_q[e0+1] || hi_q[h0+1] !== exp_hi_q[h0+1] || gap_q[g0+1] !== 1) begin
        n_fails++;
        $display("FAIL timeout_next_frame: got %h len %0d gap %0d want %h len %0d gap 1",
                 cap_q[c0+1], hi_q[h0+1], gap_q[g0+1], exp_q[e0+1], exp_hi_q[h0+1]);
      end
    end
  endtask

  task automatic test_midframe_reset();
    int n;
    int bgn_seen;
    do_write(AW'($urandom), DW'($urandom));
    do_write(AW'($urandom), DW'($urandom));
    n = 0;
    while (BGN !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
    repeat (8) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    n_checks++; if (BGN !== 1'b0)    begin n_fails++; $display("FAIL mid_reset_bgn: got %b want 0", BGN); end
    n_checks++; if (LOAD_N !== 1'b1) begin n_fails++; $display("FAIL mid_reset_load_n: got %b want 1", LOAD_N); end
    n_checks++; if (ERR !== 1'b0)    begin n_fails++; $display("FAIL mid_reset_err: got %b want 0", ERR); end
    n_checks++; if (FRAME_CNT !== 8'd0) begin n_fails++; $display("FAIL mid_reset_frame_cnt: got %0d want 0", FRAME_CNT); end
    n_checks++; if (WR_READY !== 1'b1) begin n_fails++; $display("FAIL mid_reset_wr_ready: got %b want 1", WR_READY); end
    @(negedge CLK);
    #2 RST_N = 1'b1;
    bgn_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (BGN !== 1'b0) bgn_seen++;
    end
    n_checks++;
    if (bgn_seen != 0 || BUSY !== 1'b0 || WR_READY !== 1'b1) begin
      n_fails++;
      $display("FAIL mid_reset_flushed: BGN high %0d cycles, BUSY=%b WR_READY=%b want 0,0,1", bgn_seen, BUSY, WR_READY);
    end
  endtask

  task automatic test_wrap();
    int c0, h0, e0, bad_hi;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    noise_en = 1'b1;
    c0 = cap_q.size(); h0 = hi_q.size(); e0 = exp_q.size();
    for (int i = 0; i < 512; i++) ref_vld[i] = 1'b0;
    for (int i = 0; i < 256; i++) begin
      a = AW'($urandom); d = DW'($urandom);
      ref_mem[a] = d; ref_vld[a] = 1'b1;
      do_write(a, d);
    end
    wait_idle(500, "wrap");
    noise_en = 1'b0;
    n_checks++;
    if (FRAME_CNT !== 8'd0 || FRAME_CNT !== exp_cnt) begin
      n_fails++;
      $display("FAIL wrap_frame_cnt: got %0d want 0 (model %0d)", FRAME_CNT, exp_cnt);
    end
    n_checks++;
    if (cap_q.size() - c0 != 256 || hi_q.size() - h0 != 256) begin
      n_fails++;
      $display("FAIL wrap_frames: captured %0d want 256", cap_q.size() - c0);
    end else begin
      bad_hi = 0;
      for (int i = 0; i < 256; i++) begin
        n_checks++;
        if (cap_q[c0+i] !== exp_q[e0+i]) begin
          n_fails++;
          $display("FAIL wrap_frame[%0d]: got %h want %h", i, cap_q[c0+i], exp_q[e0+i]);
        end
        if (hi_q[h0+i] !== exp_hi_q[h0+i]) bad_hi++;
      end
      n_checks++;
      if (bad_hi != 0) begin n_fails++; $display("FAIL wrap_bgn_len: %0d frames with wrong BGN length want 0", bad_hi); end
    end
    for (int i = 0; i < 512; i++) begin
      if (ref_vld[i]) begin
        n_checks++;
        if (sram_mem[i] !== ref_mem[i]) begin
          n_fails++;
          $display("FAIL wrap_sram[%0d]: got %h want %h", i, sram_mem[i], ref_mem[i]);
        end
      end
    end
    n_checks++;
    if (CTRL !== 2'b00) begin n_fails++; $display("FAIL wrap_ctrl: got %b want 00", CTRL); end
  endtask

  initial begin
    n_checks = 0; n_fails = 0; drop_req = 0; noise_en = 1'b0;
    RST_N = 1'b0; WR_VALID = 1'b0; WR_ADDR = '0; WR_DATA = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_midframe_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
